// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM states, blank code and per-digit modulus for mux_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] BLANK = 4'hF;
  function automatic logic [3:0] digit_mod(input int idx);
    return (idx == 2 || idx == 4) ? 4'd6 : 4'd10;
  endfunction
endpackage

// File: rtl/timer_bcd_digit.sv
// timer_bcd_digit: one modulo-MOD BCD counter digit with saturating load and ripple out
module timer_bcd_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       ripple
);
  localparam logic [3:0] TOP = MOD - 4'd1;
  // carry when incrementing past TOP, borrow when decrementing below zero
  assign ripple = (inc && q == TOP) || (dec && q == 4'd0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 4'd0;
    else if (load) q <= (d > TOP) ? TOP : d;
    else if (inc) q <= (q == TOP) ? 4'd0 : q + 4'd1;
    else if (dec) q <= (q == 4'd0) ? TOP : q - 4'd1;
endmodule

// File: rtl/mux_timer.sv
// mux_timer: BCD up/down timer with scanned digit output
// optional leading-zero blanking of digits >= 2 via LEADING_ZERO_BLANK_EN
module mux_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 10_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          load,
  input  logic                          dir,
  input  logic [4*NUM_DIGITS-1:0]       preset,
  output logic [3:0]                    seg_data,
  output logic [$clog2(NUM_DIGITS)-1:0] seg_an,
  output logic                          running,
  output logic                          done,
  output logic [4*NUM_DIGITS-1:0]       value
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AMAX = AW'(NUM_DIGITS - 1);
  state_t state, state_n;
  logic done_n;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [3:0] dig [NUM_DIGITS];
  logic [NUM_DIGITS:0] en;
  logic tick, dn_tick, zero, one, underflow;
  assign tick = state == RUN && tcnt == TMAX;
  assign dn_tick = tick && !dir;
  assign zero = value == '0;
  assign one = value == VW'(1);
  assign en[0] = tick;
  // a borrow out of the top digit means a down tick at zero: clamp to zero
  assign underflow = en[NUM_DIGITS] && !dir;
  assign running = state == RUN;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    timer_bcd_digit #(.MOD(digit_mod(i))) u_dig (
      .clk(clk),
      .rst(rst),
      .inc(en[i] && dir),
      .dec(en[i] && !dir),
      .load(load || underflow),
      .d(load ? preset[4*i +: 4] : 4'd0),
      .q(dig[i]),
      .ripple(en[i+1])
    );
    assign value[4*i +: 4] = dig[i];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    if (load) state_n = IDLE;
    else if (start && state != RUN) begin
      state_n = (!dir && zero) ? DONE : RUN;
      done_n  = !dir && zero;
    end else if (dn_tick && (zero || one)) begin
      state_n = DONE;
      done_n  = 1'b1;
    end else if (pause && state == RUN) state_n = PAUSE;
  end
  // prescaler only advances in RUN so a pause keeps its phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) tcnt <= '0;
    else if (load) tcnt <= '0;
    else if (state == RUN) tcnt <= tick ? '0 : tcnt + TW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scnt   <= '0;
      seg_an <= '0;
    end else if (scnt == SMAX) begin
      scnt   <= '0;
      seg_an <= (seg_an == AMAX) ? '0 : seg_an + AW'(1);
    end else scnt <= scnt + SW'(1);
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS:0] hz;
  always_comb begin
    hz = '0;
    hz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) hz[k] = hz[k+1] && dig[k] == 4'd0;
  end
  assign seg_data = (seg_an >= AW'(2) && hz[seg_an]) ? BLANK : dig[seg_an];
`else
  assign seg_data = dig[seg_an];
`endif
endmodule

// File: tb/tb_mux_timer.sv
// tb_mux_timer: table vectors, hand sequences and random stimulus against a count-based model
module tb_mux_timer;
  localparam int N = 8, TD = 4, SD = 2;
  localparam int MAXC = 36_000_000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, load = 1'b0, dir = 1'b0;
  logic [31:0] preset = '0;
  logic [3:0] seg_data;
  logic [2:0] seg_an;
  logic running, done;
  logic [31:0] value;
  int n_chk = 0, n_err = 0;
  int mods[N] = '{10, 10, 6, 10, 6, 10, 10, 10};
  int ms = S_IDLE, mc = 0, mph = 0, mscan = 0;
  bit mdone = 1'b0;

  typedef struct {
    bit st, pa, ld, dr;
    logic [31:0] pre, ev;
    bit er, ed;
  } vec_t;
  vec_t tbl[$];

  mux_timer #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load), .dir(dir),
    .preset(preset), .seg_data(seg_data), .seg_an(seg_an), .running(running),
    .done(done), .value(value)
  );

  always #5 clk = ~clk;

  // model keeps the count as a plain number of tenths; BCD only at the boundary
  function automatic logic [31:0] to_bcd(int c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(c % mods[i]);
      c = c / mods[i];
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [31:0] b);
    int c, d;
    c = 0;
    for (int i = N - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > mods[i] - 1) d = mods[i] - 1;
      c = c * mods[i] + d;
    end
    return c;
  endfunction

  function automatic logic [3:0] exp_seg(logic [31:0] v, int idx);
    logic [31:0] hi;
    hi = v >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx >= 2 && hi == 0) return 4'hF;
`endif
    return hi[3:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] ev;
    int ea;
    ev = to_bcd(mc);
    ea = (mscan / SD) % N;
    chk("value", value, ev);
    chk("running", running, ms == S_RUN);
    chk("done", done, mdone);
    chk("seg_an", seg_an, ea);
    chk("seg_data", seg_data, exp_seg(ev, ea));
  endtask

  task automatic model_edge();
    bit tk;
    int old;
    tk = ms == S_RUN && mph == TD - 1;
    old = mc;
    mdone = 1'b0;
    mscan++;
    if (load) begin
      mc = from_bcd(preset);
      ms = S_IDLE;
      mph = 0;
    end else begin
      if (ms == S_RUN) mph = (mph + 1) % TD;
      if (tk) mc = dir ? (mc + 1) % MAXC : (mc > 0 ? mc - 1 : 0);
      if (start && ms != S_RUN) begin
        ms = (!dir && old == 0) ? S_DONE : S_RUN;
        mdone = !dir && old == 0;
      end else if (tk && !dir && old <= 1) begin
        ms = S_DONE;
        mdone = 1'b1;
      end else if (pause && ms == S_RUN) ms = S_PAUSE;
    end
  endtask

  task automatic step(input bit st, input bit pa, input bit ld, input bit dr, input logic [31:0] pre);
    start = st; pause = pa; load = ld; dir = dr; preset = pre;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    start = 1'b0; pause = 1'b0; load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, dir, preset);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    ms = S_IDLE; mc = 0; mph = 0; mdone = 1'b0; mscan = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input bit st, pa, ld, dr, input logic [31:0] pre, ev, input bit er, ed);
    vec_t v;
    v.st = st; v.pa = pa; v.ld = ld; v.dr = dr; v.pre = pre; v.ev = ev; v.er = er; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    // countdown from 3: one tick every 4 RUN cycles, single done pulse
    add(0, 0, 1, 0, 32'h3, 32'h3, 0, 0);
    add(1, 0, 0, 0, 32'h3, 32'h3, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h3, 32'h3, 1, 0);
    add(0, 0, 0, 0, 32'h3, 32'h2, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h3, 32'h2, 1, 0);
    add(0, 0, 0, 0, 32'h3, 32'h1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h3, 32'h1, 1, 0);
    add(0, 0, 0, 0, 32'h3, 32'h0, 0, 1);
    add(0, 0, 0, 0, 32'h3, 32'h0, 0, 0);
    // start at zero counting down goes straight to DONE
    add(1, 0, 0, 0, 32'h3, 32'h0, 0, 1);
    add(0, 0, 0, 0, 32'h3, 32'h0, 0, 0);
    // saturating load to all-max, then up wrap to zero
    add(0, 0, 1, 1, 32'hFFFF_FFFF, 32'h9995_9599, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h9995_9599, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h9995_9599, 1, 0);
    add(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 1, 0);

    #2;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].pa, tbl[i].ld, tbl[i].dr, tbl[i].pre);
      chk($sformatf("tbl%0d_value", i), value, tbl[i].ev);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].er);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
    end

    // up ripple through d0, d1 and the mod-6 d2
    step(0, 0, 1, 1, 32'h599);
    step(1, 0, 0, 1, 32'h599);
    idle(3);
    chk("ripple_before", value, 32'h599);
    idle(1);
    chk("ripple_after", value, 32'h1000);

    // load beats start; pause then resume keeps the prescaler phase
    step(1, 0, 1, 1, 32'h42);
    chk("coinc_running", running, 1'b0);
    chk("coinc_value", value, 32'h42);
    step(1, 0, 0, 1, 32'h42);
    idle(2);
    step(0, 1, 0, 1, 32'h42);
    idle(5);
    chk("paused_value", value, 32'h42);
    chk("paused_running", running, 1'b0);
    step(1, 0, 0, 1, 32'h42);
    chk("resume_no_gain", value, 32'h42);
    idle(1);
    chk("resume_no_loss", value, 32'h43);

    // reset in the middle of a run
    step(0, 0, 1, 1, 32'h1234);
    step(1, 0, 0, 1, 32'h1234);
    idle(6);
    do_reset();
    chk("rst_value", value, 32'h0);
    chk("rst_seg_an", seg_an, 3'd0);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    idle(4);
    chk("post_rst_done", done, 1'b0);

    // scan order and leading-zero handling with value 5
    do_reset();
    step(0, 0, 1, 1, 32'h5);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] es;
      int idx;
      idle(1);
      idx = ((k + 2) / SD) % N;
      es = (idx == 0) ? 4'd5 : 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx >= 2) es = 4'hF;
`endif
      chk($sformatf("scan%0d_an", k), seg_an, idx);
      chk($sformatf("scan%0d_data", k), seg_data, es);
    end

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      bit st, pa, ld, dr;
      logic [31:0] pre;
      st = $urandom_range(7) == 0;
      pa = $urandom_range(9) == 0;
      ld = $urandom_range(19) == 0;
      dr = ($urandom_range(9) == 0) ? !dir : dir;
      pre = $urandom_range(1) ? 32'($urandom_range(5)) : $urandom;
      if (k == 200) do_reset();
      step(st, pa, ld, dr, pre);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_timer.md
MUX_TIMER -- requirements
Module: mux_timer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning displayed BCD digits, legal 4..8.
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000, meaning clk cycles per 0.1 s count tick, legal >=2.
REQ-003 SHALL have parameter SCAN_DIV, default 100_000, meaning clk cycles per display digit slot, legal >=2.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1, meaning one-cycle pulse to begin or resume counting.
REQ-007 SHALL have port pause, input, 1, meaning one-cycle pulse to freeze the count.
REQ-008 SHALL have port load, input, 1, meaning one-cycle pulse to copy preset into the count.
REQ-009 SHALL have port dir, input, 1, meaning 1 = count up, 0 = count down; sampled each tick.
REQ-010 SHALL have port preset, input, 4*NUM_DIGITS, meaning BCD load value with digit 0 in bits [3:0].
REQ-011 SHALL have port seg_data, output, 4, meaning BCD code of the digit currently scanned.
REQ-012 SHALL have port seg_an, output, $clog2(NUM_DIGITS), meaning index of the digit currently scanned.
REQ-013 SHALL have port running, output, 1, meaning high while in RUN.
REQ-014 SHALL have port done, output, 1, meaning one-cycle pulse on countdown reaching zero.
REQ-015 SHALL have port value, output, 4*NUM_DIGITS, meaning live BCD count.

Function
REQ-016 SHALL number digits from 0 upward: d0 tenths mod 10, d1 mod 10, d2 mod 6, d3 mod 10, d4 mod 6, d5..d7 mod 10.
REQ-017 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-018 SHALL follow transitions IDLE/PAUSE/DONE -start-> RUN, RUN -pause-> PAUSE, RUN -down count reaches zero-> DONE; with dir=0 and count zero, start -> DONE immediately with done pulse.
REQ-019 SHALL apply priority load > start > pause when inputs coincide; load forces IDLE and clears the prescaler.
REQ-020 SHALL run the tick prescaler only in RUN, producing one tick every TICK_DIV cycles; on pause it holds its phase.
REQ-021 SHALL update value on the clk edge following the tick: up mode +1 in d0 with ripple carry; down mode -1 with ripple borrow.
REQ-022 SHALL wrap up-count from the all-maximum value to all zeros without stopping.
REQ-023 SHALL, on a down tick making the count zero, enter DONE and assert done for exactly one cycle; count holds at zero.
REQ-024 SHALL load preset digits exceeding their modulus-1 as modulus-1 (saturate per digit).
REQ-025 SHALL advance seg_an 0..NUM_DIGITS-1 cyclically every SCAN_DIV cycles in all states, with seg_data = value digit[seg_an] in the same cycle.

Reset
REQ-026 SHALL, while rst=0, force state IDLE, value 0, prescalers 0, seg_an 0, seg_data 0, running 0, done 0, asynchronously.
REQ-027 SHALL abort any count or scan in progress on reset with no done pulse.

Configuration
REQ-028 SHALL honour macro LEADING_ZERO_BLANK_EN: when defined, seg_data = 4'hF for any digit of index >=2 that is zero with all higher digits also zero; when undefined, every digit shows its BCD value.

Structure
REQ-029 SHALL place in package timer_pkg: state enum, blank code 4'hF, digit-modulus function of index.
REQ-030 SHALL use one sub-module timer_bcd_digit (modulus parameter; inc, dec, load inputs; carry/borrow output), instanced NUM_DIGITS times.

Verification (TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=8)
REQ-031 SHALL check reset: rst=0 mid-run -> value 0, seg_an 0, running 0 next sample, no done.
REQ-032 SHALL check up ripple: load d0=9,d1=9,d2=5, dir=1, start, one tick -> d0=0,d1=0,d2=0,d3=1.
REQ-033 SHALL check countdown: load 0x00000003, dir=0, start -> value 0 after 3 ticks, single done pulse, state DONE, running 0.
REQ-034 SHALL check coincidence: load and start same cycle -> IDLE with preset loaded; pause mid-run then start -> count resumes, no tick lost or gained.
REQ-035 SHALL check scan and wrap: all-max value, dir=1, one tick -> all zeros; seg_an steps 0..7 every 2 cycles; with LEADING_ZERO_BLANK_EN and value 5, seg_data=4'hF for seg_an 2..7.
